alpha_trim_mean: RTL and testbench
==================================

// Module: alpha_trim_mean
// PURPOSE
//  Consumer and controller for parallel_sort in the modified alpha-trimmed mean filter datapath.
//  - Accepts one DN-pixel window and drives it to the sorter.
//  - Reads back the rank-ordered index vector and discards TRIM samples at each end.
//  - Accumulates the remaining N = DN-2*TRIM samples and divides the sum by N with a
//    sequential divider, emitting one DW-bit mean per window.
// PARAMETERS
//  DN      25             window sample count; must match parallel_sort DN
//  DW      8              sample width
//  TRIM    4              samples dropped at each end; 2*TRIM < DN required (TRIM=0 legal)
//  DW_SEQ  $clog2(DN)     index width; must match parallel_sort DW_sequence
//  SUMW    DW+$clog2(DN)  accumulator / divider width (13 at defaults)
// PORTS
//  clk              in   1          clock
//  rst              in   1          synchronous reset, active-high
//  win_valid        in   1          window present on win_data
//  win_data         in   DW*DN      window; sample i at [i*DW+:DW]
//  win_ready        out  1          block can accept a window
//  sort_sig         out  1          one-cycle start pulse to parallel_sort
//  data_unsort      out  DW*DN      registered window to parallel_sort
//  sequence_sorted  in   DW_SEQ*DN  from parallel_sort; slot k = index of k-th smallest sample
//  sort_finish      in   1          from parallel_sort
//  mean_valid       out  1          one-cycle pulse; mean_data is new
//  mean_data        out  DW         trimmed mean, held until the next result
// BEHAVIOUR
//  Reset values:
//  - All outputs 0 except win_ready=1; FSM returns to IDLE.
//  - Accumulator, counters and divider registers are cleared.
//  FSM states:
//  - IDLE: win_ready=1. On win_valid&&win_ready, latch win_data into data_unsort and go to KICK.
//  - KICK: sort_sig=1 for exactly this cycle; data_unsort stays stable from here until the
//    next accept. Go to WAIT.
//  - WAIT: wait for sort_finish=1, then go to SETTLE.
//  - SETTLE: sequence_sorted updates one cycle after sort_finish rises. Capture it on this
//    cycle's edge, clear sum, set k=TRIM. Go to ACCUM.
//  - ACCUM: one sample per cycle for k = TRIM .. DN-1-TRIM.
//    - sum += data_unsort[seq[k]*DW+:DW], where seq[k] = captured[k*DW_SEQ+:DW_SEQ].
//    - Exactly N cycles, then go to DIV.
//  - DIV: restoring divide of sum by constant N, one quotient bit per cycle, SUMW cycles.
//    Then go to OUT.
//  - OUT: mean_data <= quotient[DW-1:0]; mean_valid=1 for one cycle; go to IDLE.
//  Arithmetic:
//  - sum is unsigned SUMW bits and never overflows.
//  - Quotient is at most 2^DW-1, so truncation to DW bits is lossless.
//  - Remainder is discarded.
//  Latency: with sort_finish high in cycle F, mean_valid is high in cycle F+2+N+SUMW
//  (F+32 at defaults).
//  Boundary conditions:
//  - win_valid while win_ready=0: ignored, no queueing; the source must hold the window.
//  - sort_finish outside WAIT: ignored.
//  - sort_sig is never reasserted before OUT completes.
//  - Duplicate sample values: ranks are unique per parallel_sort, so every slot k maps to a
//    distinct index.
//  - rst mid-operation: abort at the next edge, sort_sig=0, mean_valid=0, back to IDLE.
//    A sort_finish arriving later is ignored.
//  - An out-of-range captured index (>=DN, sorter fault) reads as 0 and does not hang the FSM.
// CONFIGURATION
//  ALPHA_ROUND_EN
//  - Defined: in SETTLE, sum is preset to N/2 (integer) instead of 0, giving round-half-up
//    instead of floor. Latency is unchanged.
//  - Undefined: sum starts at 0 and the quotient truncates (floor).
// TESTING (defaults DN=25, DW=8, TRIM=4, N=17; bench instantiates parallel_sort)
//  1. All 25 samples = 255 -> mean_data=255, mean_valid exactly 32 cycles after sort_finish.
//  2. Ramp sample i = i (0..24) -> kept 4..20, sum=204 -> mean_data=12.
//  3. Outliers: 4x0, 20x50, 1x255 in shuffled positions -> mean_data=50.
//  4. Rounding: 4x0, 4x255, 16x10, 1x19 -> sum=179 -> mean_data=10 without ALPHA_ROUND_EN,
//     11 with it.
//  5. Back-to-back: win_valid held high across two windows -> win_ready low from accept to
//     OUT, second window accepted only in IDLE, two correct mean_valid pulses.
//  6. Assert rst for 1 cycle mid-ACCUM -> next cycle mean_valid=0, win_ready=1; the following
//     window (test 2) gives 12.

Source files
------------

// File: rtl/alpha_trim_mean.sv
// Alpha-trimmed mean controller: drives a window to parallel_sort, sums the middle ranks and divides by N.
// Define ALPHA_ROUND_EN to round half-up instead of truncating the quotient.
module alpha_trim_mean #(
    parameter int DN     = 25,
    parameter int DW     = 8,
    parameter int TRIM   = 4,
    parameter int DW_SEQ = $clog2(DN),
    parameter int SUMW   = DW + $clog2(DN)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 win_valid,
    input  logic [DW*DN-1:0]     win_data,
    output logic                 win_ready,
    output logic                 sort_sig,
    output logic [DW*DN-1:0]     data_unsort,
    input  logic [DW_SEQ*DN-1:0] sequence_sorted,
    input  logic                 sort_finish,
    output logic                 mean_valid,
    output logic [DW-1:0]        mean_data
);

    localparam int N  = DN - 2 * TRIM;
    localparam int CW = $clog2(SUMW + 1);
    localparam logic [DW_SEQ-1:0] K_FIRST = DW_SEQ'(TRIM);
    localparam logic [DW_SEQ-1:0] K_LAST  = DW_SEQ'(DN - 1 - TRIM);
    localparam logic [SUMW-1:0]   N_S     = SUMW'(N);
`ifdef ALPHA_ROUND_EN
    localparam logic [SUMW-1:0]   SUM_INIT = SUMW'(N / 2);
`else
    localparam logic [SUMW-1:0]   SUM_INIT = '0;
`endif

    typedef enum logic [2:0] {IDLE, KICK, WAIT, SETTLE, ACCUM, DIV, OUT} state_t;

    state_t                 state, state_next;
    logic [DW_SEQ*DN-1:0]   captured;
    logic [DW_SEQ-1:0]      k;
    logic [SUMW-1:0]        sum;
    logic [SUMW-1:0]        rem;
    logic [CW-1:0]          bit_cnt;
    logic [DW_SEQ-1:0]      idx;
    logic [DW-1:0]          pick;
    logic [SUMW:0]          trial;
    logic [SUMW:0]          diff;
    logic                   q_bit;
    logic [SUMW-1:0]        rem_next;
    logic                   last_bit;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (win_valid) state_next = KICK;
            KICK:    state_next = WAIT;
            WAIT:    if (sort_finish) state_next = SETTLE;
            SETTLE:  state_next = ACCUM;
            ACCUM:   if (k == K_LAST) state_next = DIV;
            DIV:     if (last_bit) state_next = OUT;
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        win_ready  = (state == IDLE);
        sort_sig   = (state == KICK);
        mean_valid = (state == OUT);
    end

    // Rank lookup; an index at or beyond DN (sorter fault) contributes 0
    always_comb begin
        idx  = captured[k*DW_SEQ +: DW_SEQ];
        pick = '0;
        for (int i = 0; i < DN; i++) begin
            if (idx == DW_SEQ'(i)) pick = data_unsort[i*DW +: DW];
        end
    end

    // Restoring divider: sum doubles as the dividend/quotient shift register
    always_comb begin
        trial    = {rem, sum[SUMW-1]};
        diff     = trial - {1'b0, N_S};
        q_bit    = (trial >= {1'b0, N_S});
        rem_next = q_bit ? diff[SUMW-1:0] : trial[SUMW-1:0];
        last_bit = (bit_cnt == CW'(SUMW - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_unsort <= '0;
            captured    <= '0;
            k           <= '0;
            sum         <= '0;
            rem         <= '0;
            bit_cnt     <= '0;
            mean_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) data_unsort <= win_data;
                end
                SETTLE: begin
                    captured <= sequence_sorted;
                    sum      <= SUM_INIT;
                    k        <= K_FIRST;
                    rem      <= '0;
                    bit_cnt  <= '0;
                end
                ACCUM: begin
                    sum <= sum + SUMW'(pick);
                    if (k != K_LAST) k <= k + 1'b1;
                end
                DIV: begin
                    sum     <= {sum[SUMW-2:0], q_bit};
                    rem     <= rem_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (last_bit) mean_data <= {sum[DW-2:0], q_bit};
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alpha_trim_mean.sv
// Self-checking bench for alpha_trim_mean with a behavioural parallel_sort model and a mean scoreboard.
module tb_alpha_trim_mean;

    localparam int DN     = 25;
    localparam int DW     = 8;
    localparam int TRIM   = 4;
    localparam int DW_SEQ = 5;
    localparam int SUMW   = 13;
    localparam int N      = DN - 2 * TRIM;
    localparam int LAT    = 2 + N + SUMW;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 win_valid;
    logic [DW*DN-1:0]     win_data;
    logic                 win_ready;
    logic                 sort_sig;
    logic [DW*DN-1:0]     data_unsort;
    logic [DW_SEQ*DN-1:0] sequence_sorted;
    logic                 sort_finish;
    logic                 mean_valid;
    logic [DW-1:0]        mean_data;

    int tests_run = 0;
    int failures  = 0;
    int cyc = 0;
    int finish_cyc = 0;
    int finish_cnt = 0;
    int sort_pulses = 0;
    int accepted = 0;
    int means_seen = 0;
    int exp_q[$];
    logic [DW-1:0] vals [DN];

    alpha_trim_mean dut (
        .clk(clk), .rst(rst), .win_valid(win_valid), .win_data(win_data),
        .win_ready(win_ready), .sort_sig(sort_sig), .data_unsort(data_unsort),
        .sequence_sorted(sequence_sorted), .sort_finish(sort_finish),
        .mean_valid(mean_valid), .mean_data(mean_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [DW*DN-1:0] packVals();
        logic [DW*DN-1:0] w;
        for (int i = 0; i < DN; i++) w[i*DW +: DW] = vals[i];
        return w;
    endfunction

    function automatic int modelMean(input logic [DW*DN-1:0] w);
        int s[DN];
        int t, acc;
        for (int i = 0; i < DN; i++) s[i] = int'(w[i*DW +: DW]);
        for (int i = 0; i < DN - 1; i++)
            for (int j = 0; j < DN - 1 - i; j++)
                if (s[j] > s[j+1]) begin t = s[j]; s[j] = s[j+1]; s[j+1] = t; end
        acc = 0;
        for (int i = TRIM; i < DN - TRIM; i++) acc += s[i];
`ifdef ALPHA_ROUND_EN
        acc += N / 2;
`endif
        return acc / N;
    endfunction

    // Behavioural parallel_sort: stable ranks, finish pulse after a varying delay, ranks one cycle later
    initial begin
        logic [DW_SEQ*DN-1:0] seq;
        logic [DW-1:0] v [DN];
        int rank;
        sort_finish = 1'b0;
        sequence_sorted = '0;
        forever begin
            @(negedge clk);
            if (sort_sig) begin
                sort_pulses++;
                for (int i = 0; i < DN; i++) v[i] = data_unsort[i*DW +: DW];
                seq = '0;
                for (int i = 0; i < DN; i++) begin
                    rank = 0;
                    for (int j = 0; j < DN; j++)
                        if (v[j] < v[i] || (v[j] == v[i] && j < i)) rank++;
                    seq[rank*DW_SEQ +: DW_SEQ] = DW_SEQ'(i);
                end
                repeat (1 + sort_pulses % 3) @(posedge clk);
                #1 sort_finish = 1'b1;
                finish_cyc = cyc;
                finish_cnt++;
                @(posedge clk);
                #1 sort_finish = 1'b0;
                sequence_sorted = seq;
            end
        end
    end

    always @(negedge clk) begin
        if (mean_valid) begin
            means_seen++;
            if (exp_q.size() == 0) begin
                checkOutput("spurious_mean", {31'b0, mean_valid}, 0);
            end else begin
                checkOutput("mean", {24'b0, mean_data}, exp_q.pop_front());
                checkOutput("latency", cyc - finish_cyc, LAT);
            end
        end
    end

    task automatic applyStimulus(input logic [DW*DN-1:0] w, input int exp_mean, input bit hold);
        int waited;
        win_data  = w;
        win_valid = 1'b1;
        waited = 0;
        while (!win_ready && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        if (!win_ready) begin
            checkOutput("accept_timeout", {31'b0, win_ready}, 1);
            win_valid = 1'b0;
        end else begin
            @(posedge clk);
            exp_q.push_back(exp_mean);
            accepted++;
            #1;
            if (!hold) win_valid = 1'b0;
        end
    endtask

    task automatic waitDrain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            @(posedge clk);
            waited++;
        end
        #1;
        checkOutput("drain", exp_q.size(), 0);
    endtask

    initial begin
        logic [DW*DN-1:0] ramp, w;
        int j, t, start, waited, prior;
        rst = 1'b1;
        win_valid = 1'b0;
        win_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_win_ready", {31'b0, win_ready}, 1);
        checkOutput("rst_mean_valid", {31'b0, mean_valid}, 0);
        checkOutput("rst_sort_sig", {31'b0, sort_sig}, 0);
        checkOutput("rst_mean_data", {24'b0, mean_data}, 0);
        checkOutput("rst_data_unsort", {31'b0, |data_unsort}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: all 255
        for (int i = 0; i < DN; i++) vals[i] = 8'd255;
        applyStimulus(packVals(), 255, 1'b0);
        waitDrain();

        // Test 2: ramp
        for (int i = 0; i < DN; i++) vals[i] = DW'(i);
        ramp = packVals();
        applyStimulus(ramp, 12, 1'b0);
        waitDrain();

        // Test 3: outliers in shuffled positions
        for (int i = 0; i < DN; i++) vals[i] = (i < 4) ? 8'd0 : (i < 24) ? 8'd50 : 8'd255;
        for (int i = DN - 1; i > 0; i--) begin
            j = $urandom_range(i, 0);
            t = int'(vals[i]); vals[i] = vals[j]; vals[j] = DW'(t);
        end
        applyStimulus(packVals(), 50, 1'b0);
        waitDrain();

        // Test 4: rounding case
        for (int i = 0; i < DN; i++) vals[i] = (i < 4) ? 8'd0 : (i < 8) ? 8'd255 : (i < 24) ? 8'd10 : 8'd19;
`ifdef ALPHA_ROUND_EN
        applyStimulus(packVals(), 11, 1'b0);
`else
        applyStimulus(packVals(), 10, 1'b0);
`endif
        waitDrain();

        // Test 5: back-to-back with win_valid held high
        prior = means_seen;
        applyStimulus(ramp, 12, 1'b1);
        for (int i = 0; i < DN; i++) vals[i] = DW'(3 * i + 1);
        w = packVals();
        win_data = w;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("busy_ready", {31'b0, win_ready}, 0);
        end
        #1;
        applyStimulus(w, modelMean(w), 1'b0);
        checkOutput("b2b_order", means_seen, prior + 1);
        waitDrain();
        checkOutput("b2b_count", means_seen, prior + 2);

        // Test 6: reset mid-ACCUM, then ramp again
        start = finish_cnt;
        applyStimulus(ramp, 12, 1'b0);
        waited = 0;
        while (finish_cnt == start && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("finish_timeout", finish_cnt, start + 1);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checkOutput("abort_mean_valid", {31'b0, mean_valid}, 0);
        checkOutput("abort_win_ready", {31'b0, win_ready}, 1);
        checkOutput("abort_sort_sig", {31'b0, sort_sig}, 0);
        #1;
        applyStimulus(ramp, 12, 1'b0);
        waitDrain();

        // A few random windows against the reference model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DN; i++) vals[i] = DW'($urandom_range(255, 0));
            w = packVals();
            applyStimulus(w, modelMean(w), 1'b0);
            waitDrain();
        end

        checkOutput("sort_pulses", sort_pulses, accepted);
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end

endmodule
